// File: rtl/mult_pkg.sv
// Shared constants and saturation helpers for the
// fixed-point multiply pipeline.
package mult_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FRAC_BITS  = 10;
  localparam int LATENCY        = 3;
  localparam int SAT_W          = 129;

  // Wide enough for any DATA_WIDTH up to 64.
  function automatic logic signed [SAT_W-1:0] sat_max(input int w);
    return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_min(input int w);
    return -(SAT_W'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/mult_pipe_if.sv
// Operand/result handshake bundle for mult_pipe.
// master drives operands and out_ready; slave is the pipe.
interface mult_pipe_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] multiplicand;
  logic [DATA_WIDTH-1:0] multiplier;
  logic                  round_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] product;
  logic                  out_sat;
  logic                  sat_sticky;

  modport master (
    output in_valid, multiplicand, multiplier,
    output round_en, out_ready,
    input  in_ready, out_valid, product,
    input  out_sat, sat_sticky
  );

  modport slave (
    input  in_valid, multiplicand, multiplier,
    input  round_en, out_ready,
    output in_ready, out_valid, product,
    output out_sat, sat_sticky
  );

endinterface

// File: rtl/mult_round_sat.sv
// Round-half-up, arithmetic scale and clamp of a full
// precision signed product. Purely combinational.
module mult_round_sat
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic signed [2*DATA_WIDTH-1:0] p_i,
  input  logic                           rnd_i,
  output logic        [DATA_WIDTH-1:0]   res_o,
  output logic                           sat_o
);

  localparam int SW = 2*DATA_WIDTH + 1;

  // Half an LSB of the result; collapses to zero when FRAC_BITS is 0.
  localparam logic signed [SW-1:0] RND =
    SW'((SW'(1) << FRAC_BITS) >> 1);
  localparam logic signed [SW-1:0] MAXV =
    SW'(sat_max(DATA_WIDTH));
  localparam logic signed [SW-1:0] MINV =
    SW'(sat_min(DATA_WIDTH));

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shf;
  logic                 hi;
  logic                 lo;

  always_comb begin
    sum = SW'(p_i) + (rnd_i ? RND : '0);
    shf = sum >>> FRAC_BITS;
    hi  = shf > MAXV;
    lo  = shf < MINV;
    sat_o = hi | lo;
    unique case (1'b1)
      hi:      res_o = MAXV[DATA_WIDTH-1:0];
      lo:      res_o = MINV[DATA_WIDTH-1:0];
      default: res_o = shf[DATA_WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/mult_pipe.sv
// Three-stage signed fixed-point multiplier with
// valid/ready flow control and saturation flags.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input logic        clock,
  input logic        reset_n,
  mult_pipe_if.slave bus
);

  localparam int PW = 2*DATA_WIDTH;

  logic                         advance;
  logic                         v1_q, v2_q, v3_q;
  logic signed [DATA_WIDTH-1:0] a_q, b_q;
  logic                         rnd1_q, rnd2_q;
  logic signed [PW-1:0]         p_d, p_q;
  logic        [DATA_WIDTH-1:0] res_d, prod_q;
  logic                         sat_d, sat_q;
  logic                         sticky_q;

  // Whole pipe freezes together when the output is blocked.
  assign advance = !v3_q || bus.out_ready;
  assign p_d     = PW'(a_q) * PW'(b_q);

  mult_round_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_round_sat (
    .p_i   (p_q),
    .rnd_i (rnd2_q),
    .res_o (res_d),
    .sat_o (sat_d)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rnd1_q   <= 1'b0;
      rnd2_q   <= 1'b0;
      p_q      <= '0;
      prod_q   <= '0;
      sat_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else if (advance) begin
      v1_q <= bus.in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (bus.in_valid) begin
        a_q    <= bus.multiplicand;
        b_q    <= bus.multiplier;
        rnd1_q <= bus.round_en;
      end
      if (v1_q) begin
        p_q    <= p_d;
        rnd2_q <= rnd1_q;
      end
      if (v2_q) begin
        prod_q   <= res_d;
        sat_q    <= sat_d;
        sticky_q <= sticky_q | sat_d;
      end
    end
  end

  assign bus.in_ready   = advance;
  assign bus.out_valid  = v3_q;
  assign bus.product    = prod_q;
  assign bus.out_sat    = sat_q;
  assign bus.sat_sticky = sticky_q;

endmodule

// File: tb/tb_mult_pipe.sv
// Randomized and directed bench for mult_pipe against
// an arithmetic reference model.
module tb_mult_pipe;

  localparam int DW = 32;
  localparam int FB = 10;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  mult_pipe_if #(.DATA_WIDTH(DW)) bus ();

  mult_pipe #(
    .DATA_WIDTH (DW),
    .FRAC_BITS  (FB)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  logic [31:0] exp_y_q[$];
  logic        exp_s_q[$];
  logic [31:0] last_prod;
  logic        last_sat;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_prod;
  logic        prev_sat;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a,
                                input logic [31:0] b,
                                input logic r,
                                output logic [31:0] y,
                                output logic s);
    longint pa, pb, p;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = pa * pb;
    if (r) p = p + 512;
    p = p >>> FB;
    if (p > 64'sd2147483647) begin
      y = 32'h7fff_ffff; s = 1'b1;
    end else if (p < -64'sd2147483648) begin
      y = 32'h8000_0000; s = 1'b1;
    end else begin
      y = p[31:0]; s = 1'b0;
    end
  endfunction

  initial forever begin
    logic [31:0] y;
    logic        s;
    @(negedge clock);
    if (!reset_n) begin
      chk("rst_ov", bus.out_valid, 0);
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_v", bus.out_valid, 1);
        chk("hold_p", bus.product, prev_prod);
        chk("hold_s", bus.out_sat, prev_sat);
      end
      if (exp_y_q.size() == 0)
        chk("spurious", bus.out_valid, 0);
      if (bus.out_valid && bus.out_ready && exp_y_q.size() > 0) begin
        chk("prod", bus.product, exp_y_q.pop_front());
        chk("sat", bus.out_sat, exp_s_q.pop_front());
        last_prod = bus.product;
        last_sat  = bus.out_sat;
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        model(bus.multiplicand, bus.multiplier, bus.round_en, y, s);
        exp_y_q.push_back(y);
        exp_s_q.push_back(s);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_prod  = bus.product;
      prev_sat   = bus.out_sat;
    end
  end

  task automatic send(input logic [31:0] a,
                      input logic [31:0] b,
                      input logic r);
    int n = 0;
    logic acc = 1'b0;
    bus.in_valid     = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.round_en     = r;
    while (!acc && n < 200) begin
      @(negedge clock);
      acc = bus.in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    chk("send_acc", acc, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_y_q.size() != 0 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain", exp_y_q.size(), 0);
  endtask

  task automatic one(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic r,
                     input logic [31:0] ey,
                     input logic es);
    send(a, b, r);
    drain();
    chk(tag, last_prod, ey);
    chk(tag, last_sat, es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    logic [31:0] bpa[5];
    logic [31:0] bpb[5];
    int idx;
    int outs0;
    int n;
    logic took;

    bus.in_valid     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.round_en     = 1'b0;
    bus.out_ready    = 1'b1;

    #2 reset_n = 1'b0;
    @(negedge clock);
    chk("rst_prod", bus.product, 0);
    chk("rst_sat", bus.out_sat, 0);
    chk("rst_sticky", bus.sat_sticky, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rel_rdy", bus.in_ready, 1);
    @(posedge clock);
    #1;

    send(32'h400, 32'h400, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("latency", bus.out_valid, (k == 2) ? 1 : 0);
    end
    @(posedge clock);
    #1;
    drain();
    chk("one_p", last_prod, 32'h400);
    chk("one_s", last_sat, 0);

    one("neg_pos", 32'hffff_fc00, 32'h400, 1'b0, 32'hffff_fc00, 1'b0);
    one("neg_neg", 32'hffff_fc00, 32'hffff_fc00, 1'b0, 32'h400, 1'b0);
    one("rnd_on", 32'h1, 32'h200, 1'b1, 32'h1, 1'b0);
    one("rnd_off", 32'h1, 32'h200, 1'b0, 32'h0, 1'b0);
    one("sat_hi", 32'h7fff_ffff, 32'h7fff_ffff, 1'b0,
        32'h7fff_ffff, 1'b1);
    chk("sticky", bus.sat_sticky, 1);
    one("sat_lo", 32'h8000_0000, 32'h7fff_ffff, 1'b0,
        32'h8000_0000, 1'b1);

    bpa = '{32'h400, 32'hffff_f800, 32'h1234, 32'h7fff_ffff, 32'h3};
    bpb = '{32'h800, 32'h400, 32'hffff_ff00, 32'h2, 32'h155};
    outs0 = n_out;
    idx = 0;
    bus.out_ready    = 1'b0;
    bus.in_valid     = 1'b1;
    bus.multiplicand = bpa[0];
    bus.multiplier   = bpb[0];
    bus.round_en     = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      took = bus.in_ready;
      @(posedge clock);
      #1;
      if (took) idx++;
      if (idx < 5) begin
        bus.multiplicand = bpa[idx];
        bus.multiplier   = bpb[idx];
      end
    end
    chk("bp_acc", idx, 3);
    chk("bp_rdy", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    n = 0;
    while (idx < 5 && n < 50) begin
      @(negedge clock);
      took = bus.in_ready;
      @(posedge clock);
      #1;
      if (took) idx++;
      if (idx < 5) begin
        bus.multiplicand = bpa[idx];
        bus.multiplier   = bpb[idx];
      end
      n++;
    end
    bus.in_valid = 1'b0;
    drain();
    chk("bp_out", n_out - outs0, 5);

    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(9) < 7);
      bus.out_ready = ($urandom_range(9) < 6);
      bus.round_en  = 1'($urandom_range(1));
      if ($urandom_range(1) == 1) begin
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
      end else begin
        bus.multiplicand = 32'($urandom_range(8191)) - 32'd4096;
        bus.multiplier   = 32'($urandom_range(8191)) - 32'd4096;
      end
      @(posedge clock);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    send(32'h7fff_ffff, 32'h7fff_ffff, 1'b0);
    send(32'h400, 32'h400, 1'b0);
    reset_n = 1'b0;
    exp_y_q.delete();
    exp_s_q.delete();
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rel_rdy2", bus.in_ready, 1);
    chk("rst_sticky2", bus.sat_sticky, 0);
    repeat (6) begin
      @(negedge clock);
      chk("stale", bus.out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
